hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit directly upstream of the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU on two WIDTH-bit operands from the EX stage.
- Stalls the pipeline while it works, then presents one write pulse with the hi/lo result to the HI/LO write port.
- Its o_we/o_hi/o_lo are OR-merged with the other HI/LO writers.

Parameters:
- WIDTH, 32, operand and result word width; iteration count per operation.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-low reset; state is cleared on a posedge where rst==0.
- i_start  input  1  request a new operation; sampled only when the unit can accept.
- i_op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- i_a  input  WIDTH  multiplicand or dividend (rs).
- i_b  input  WIDTH  multiplier or divisor (rt).
- i_cancel  input  1  pipeline flush; aborts the operation in flight.
- o_busy  output  1  stall request to the pipeline.
- o_we  output  1  one-cycle HI/LO write strobe.
- o_hi  output  WIDTH  MULT*: product[2W-1:W]; DIV*: remainder.
- o_lo  output  WIDTH  MULT*: product[W-1:0]; DIV*: quotient.

Behaviour:
- State machine: IDLE, CALC, FIX, DONE.
- Reset values: state=IDLE, o_busy=0, o_we=0, o_hi=0, o_lo=0, iteration counter=0. Reset overrides everything, including an operation in flight; no o_we is produced for it.
- o_busy = (state==CALC || state==FIX); it is a decode of registered state.
- o_we = (state==DONE).
- o_hi/o_lo are registered. They load on entry to DONE and hold until the next DONE.

Starting and cycle numbering:
- i_start is accepted in IDLE or DONE and ignored in CALC/FIX.
- Call the acceptance cycle cycle 0. At that edge the unit latches op, |i_a|, |i_b| (absolute values for signed ops), the sign flags and counter=WIDTH, then enters CALC.

CALC:
- Multiply: radix-2 shift-add on a 2W-bit accumulator, one bit per cycle.
- Divide: restoring, one quotient bit per cycle; remainder register is W+1 bits.
- Counter decrements each cycle. When it reaches 0, go to FIX.
- Timing: CALC occupies cycles 1..WIDTH, FIX is cycle WIDTH+1, DONE is cycle WIDTH+2 (o_we=1 for exactly one cycle). Then return to IDLE, unless i_start is high in DONE, in which case go straight to CALC.

FIX:
- MULT: negate the 2W-bit product if the operand signs differ.
- DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- All arithmetic wraps modulo 2^W.
- Signed MIN / -1 gives quotient = 0x80000000, remainder = 0, with no exception.
- MULT of MIN*MIN is exact in 2W bits.

Divide by zero (DIV/DIVU with i_b==0):
- Detected in cycle 0; the unit goes IDLE→DONE, skipping CALC/FIX.
- o_we pulses in cycle 1 with o_hi = i_a (as given), o_lo = all ones.
- o_busy stays 0.

Cancel:
- i_cancel in CALC or FIX → IDLE at the next edge; no o_we.
- i_cancel in DONE does not suppress the current o_we, because the write belongs to an already-retired instruction.
- i_cancel together with i_start in IDLE: the start is dropped.
- i_cancel has priority over i_start in every state.

Optional Feature:
- Macro: HILO_MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiplier. An accepted multiply goes IDLE→DONE with the signed/unsigned product, so o_we is in cycle 1 and o_busy never rises. Divides are unchanged.
- Undefined: multiplies take the iterative path described above, with o_we in cycle WIDTH+2.

Test Plan:
- Reset: hold rst=0 for 2 cycles → o_busy=0, o_we=0, o_hi=o_lo=0x00000000. Release, idle 5 cycles → no o_we.
- MULTU 7×6 → o_we only in cycle 34 (macro off) or cycle 1 (macro on), with o_hi=0x00000000, o_lo=0x0000002A. o_busy=1 in cycles 1..33.
- MULT 0xFFFFFFFF×0x00000002 → o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFE. DIV 0xFFFFFFF9/0x00000002 → o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF, in cycle 34.
- DIV 0x80000000/0xFFFFFFFF → o_lo=0x80000000, o_hi=0. DIVU 0x12345678/0 → cycle-1 o_we with o_hi=0x12345678, o_lo=0xFFFFFFFF, o_busy never 1.
- DIVU 100/7 with i_cancel in cycle 10 → o_busy low from cycle 11, no o_we, o_hi/o_lo retain previous values. Back-to-back: i_start asserted in the DONE cycle → second o_we exactly 34 cycles later.
- Reset mid-operation: rst=0 in cycle 15 of a DIVU → IDLE, outputs zero, no o_we. i_start in cycles 5..20 while busy → ignored, single o_we.

Source files
------------

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write port.
// Define HILO_MULDIV_FAST_MUL_EN for a single-cycle multiplier; divides stay iterative.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_we,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;

  logic               in_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed ops are decoded from i_op[0]==0; magnitudes are iterated, signs applied in FIX.
  assign in_div = i_op[1];
  assign a_neg  = ~i_op[0] & i_a[WIDTH-1];
  assign b_neg  = ~i_op[0] & i_b[WIDTH-1];
  assign a_abs  = a_neg ? -i_a : i_a;
  assign b_abs  = b_neg ? -i_b : i_b;

  // Multiply step: prod_q holds {partial sum, remaining multiplier bits}.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};

  // Divide step: prod_q[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign div_shift = {rem_q, prod_q[WIDTH-1]};
  assign div_ge    = div_shift >= {2'b00, b_q};
  assign div_rem   = div_ge ? RW'(div_shift - {2'b00, b_q}) : RW'(div_shift);

  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign quo_fix  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

`ifdef HILO_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{a_neg}}, i_a} * {{WIDTH{b_neg}}, i_b};
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_cancel) begin
          state_d = IDLE;
        end else if (i_start) begin
          div_d  = in_div;
          neg_d  = a_neg ^ b_neg;
          sa_d   = a_neg;
          cnt_d  = CW'(WIDTH);
          a_d    = a_abs;
          b_d    = b_abs;
          rem_d  = '0;
          prod_d = {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
          if (in_div && (i_b == '0)) begin
            hi_d    = i_a;
            lo_d    = '1;
            state_d = DONE;
          end
`ifdef HILO_MULDIV_FAST_MUL_EN
          else if (!in_div) begin
            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            state_d = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (i_cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (div_q) begin
            rem_d  = div_rem;
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], div_ge};
          end else begin
            prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (i_cancel) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
    end
  end

  assign o_busy = (state_q == CALC) || (state_q == FIX);
  assign o_we   = (state_q == DONE);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO writes, a monitor pops on o_we.
// Honours HILO_MULDIV_FAST_MUL_EN for multiply latency.
module tb_hilo_muldiv;

`ifdef HILO_MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  localparam int MUL_LAT  = 1;
`else
  localparam bit FAST_MUL = 1'b0;
  localparam int MUL_LAT  = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_cancel = 1'b0;
  logic        o_busy, o_we;
  logic [31:0] o_hi, o_lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   busy_cnt, busy_bad;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cancel(i_cancel),
    .o_busy  (o_busy),
    .o_we    (o_we),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one start for one cycle; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit expect_we, input logic [31:0] ehi, input logic [31:0] elo,
                               input int lat);
    @(negedge clk);
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    if (expect_we) exp_q.push_back('{hi: ehi, lo: elo, cyc: cyc + lat});
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (o_we) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_we: got write hi=0x%0h lo=0x%0h at cycle %0d, expected none",
                 o_hi, o_lo, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("we_hi", {32'd0, o_hi}, {32'd0, e.hi});
        checkOutput("we_lo", {32'd0, o_lo}, {32'd0, e.lo});
        checkOutput("we_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idle(2);
    checkOutput("reset_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("reset_we", {63'd0, o_we}, 64'd0);
    checkOutput("reset_hi", {32'd0, o_hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, o_lo}, 64'd0);
    rst = 1'b1;
    idle(5);

    applyStimulus(2'b01, 32'd7, 32'd6, 1'b1, 32'h0, 32'h2A, MUL_LAT);
    busy_cnt = 0;
    busy_bad = 0;
    for (int k = 1; k <= 35; k++) begin
      if (o_busy) busy_cnt++;
      if (o_busy !== (!FAST_MUL && k <= 33)) busy_bad++;
      @(negedge clk);
    end
    checkOutput("multu_busy_cycles", 64'(busy_cnt), FAST_MUL ? 64'd0 : 64'd33);
    checkOutput("multu_busy_pattern", 64'(busy_bad), 64'd0);
    idle(2);

    applyStimulus(2'b00, 32'hFFFFFFFF, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    idle(36);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
    idle(36);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, DIV_LAT);
    idle(36);
    applyStimulus(2'b00, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, MUL_LAT);
    idle(36);

    applyStimulus(2'b11, 32'h12345678, 32'h0, 1'b1, 32'h12345678, 32'hFFFFFFFF, 1);
    busy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_busy) busy_cnt++;
      @(negedge clk);
    end
    checkOutput("divzero_busy", 64'(busy_cnt), 64'd0);
    applyStimulus(2'b10, 32'hFFFFFF00, 32'h0, 1'b1, 32'hFFFFFF00, 32'hFFFFFFFF, 1);
    idle(3);

    // Cancel in cycle 10 of a DIVU: no write, outputs keep the divide-by-zero result.
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 0);
    idle(9);
    i_cancel = 1'b1;
    @(negedge clk);
    i_cancel = 1'b0;
    checkOutput("cancel_busy", {63'd0, o_busy}, 64'd0);
    idle(40);
    checkOutput("cancel_hold_hi", {32'd0, o_hi}, {32'd0, 32'hFFFFFF00});
    checkOutput("cancel_hold_lo", {32'd0, o_lo}, {32'd0, 32'hFFFFFFFF});

    // Back-to-back: second start lands in the first operation's DONE cycle.
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, DIV_LAT);
    idle(32);
    applyStimulus(2'b10, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFF2, DIV_LAT);
    idle(36);

    applyStimulus(2'b11, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0, 0);
    idle(14);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midreset_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("midreset_we", {63'd0, o_we}, 64'd0);
    checkOutput("midreset_hi", {32'd0, o_hi}, 64'd0);
    checkOutput("midreset_lo", {32'd0, o_lo}, 64'd0);
    idle(40);

    applyStimulus(2'b11, 32'd1000, 32'd10, 1'b1, 32'd0, 32'd100, DIV_LAT);
    idle(4);
    i_start = 1'b1;
    i_op    = 2'b11;
    i_a     = 32'd5;
    i_b     = 32'd0;
    idle(16);
    i_start = 1'b0;
    idle(20);

    @(negedge clk);
    i_start  = 1'b1;
    i_cancel = 1'b1;
    i_op     = 2'b11;
    i_a      = 32'd9;
    i_b      = 32'd0;
    @(negedge clk);
    i_start  = 1'b0;
    i_cancel = 1'b0;
    checkOutput("cancel_start_busy", {63'd0, o_busy}, 64'd0);
    idle(5);

    applyStimulus(2'b11, 32'd77, 32'd0, 1'b1, 32'd77, 32'hFFFFFFFF, 1);
    i_cancel = 1'b1;
    @(negedge clk);
    i_cancel = 1'b0;
    idle(3);

    checkOutput("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
